// File: rtl/bar_width_sampler.sv
// bar_width_sampler
//   Front end of the bar-code reader. It synchronises the raw optical line and
//   measures each dark bar in clock cycles. Each bar is classified narrow/wide
//   against the first bar of the scan, and every five bars are packed into a
//   2-of-5 symbol word.
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   asynchronous reset, active low
//   scan      in   raw optical line (async), 1 = dark bar
//   I         out  last completed symbol, first bar in bit 4
//   I_VALID   out  one-cycle strobe, new symbol in I
//   I_ERR     out  one-cycle strobe, popcount != 2, run saturation or partial symbol at timeout
//   END_SCAN  out  one-cycle strobe, quiet light run ended the scan
//   state     out  FSM state: IDLE=0, REF=1, BAR=2, GAP=3
module bar_width_sampler #(
    parameter int CW    = 8,
    parameter int QUIET = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scan,
    output logic [4:0] I,
    output logic       I_VALID,
    output logic       I_ERR,
    output logic       END_SCAN,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REF  = 2'd1,
        BAR  = 2'd2,
        GAP  = 2'd3
    } state_e;

    localparam logic [CW-1:0] RUN_MAX = '1;
    localparam logic [CW-1:0] QUIET_C = CW'(QUIET);

    logic          sync1_q, scan_s_q, scan_p_q;
    logic [CW-1:0] run_q, run_d;
    logic [CW-1:0] ref_q, ref_d;
    // Only the four earlier bars are stored; the fifth goes straight into I.
    logic [3:0]    sr_q, sr_d;
    logic [2:0]    nb_q, nb_d;
    logic [4:0]    i_q, i_d;
    logic          ivld_q, ivld_d;
    logic          ierr_q, ierr_d;
    logic          end_q, end_d;
    state_e        st_q, st_d;

    logic          rise, fall, wide;
    logic [CW+1:0] two_w, three_r;
    logic [4:0]    sr_shift;

    assign rise = scan_s_q & ~scan_p_q;
    assign fall = ~scan_s_q & scan_p_q;

    // 2*w > 3*ref evaluated two bits wider than the counter so 3*ref cannot wrap.
    assign two_w    = {1'b0, run_q, 1'b0};
    assign three_r  = {2'b00, ref_q} + {1'b0, ref_q, 1'b0};
    assign wide     = two_w > three_r;
    assign sr_shift = {sr_q, wide};

    always_comb begin
        st_d   = st_q;
        ref_d  = ref_q;
        sr_d   = sr_q;
        nb_d   = nb_q;
        i_d    = i_q;
        ivld_d = 1'b0;
        ierr_d = 1'b0;
        end_d  = 1'b0;

        // The run counter restarts at 1 on every edge: the edge cycle is the first cycle of the new run.
        if (rise || fall)          run_d = CW'(1);
        else if (run_q == RUN_MAX) run_d = run_q;
        else                       run_d = run_q + CW'(1);

        case (st_q)
            IDLE: begin
                if (rise) st_d = REF;
            end
            REF: begin
                if (fall) begin
                    ref_d = run_q;
                    st_d  = GAP;
                end else if (run_q == RUN_MAX) begin
                    ierr_d = 1'b1;
                    nb_d   = '0;
                    st_d   = IDLE;
                end
            end
            BAR: begin
                if (fall) begin
                    sr_d = sr_shift[3:0];
                    st_d = GAP;
                    if (nb_q == 3'd4) begin
                        i_d    = sr_shift;
                        ivld_d = 1'b1;
                        ierr_d = ($countones(sr_shift) != 2);
                        nb_d   = '0;
                    end else begin
                        nb_d = nb_q + 3'd1;
                    end
                end else if (run_q == RUN_MAX) begin
                    ierr_d = 1'b1;
                    nb_d   = '0;
                    st_d   = IDLE;
                end
            end
            GAP: begin
                // A light run of exactly QUIET cycles ends the scan even if a bar starts that cycle.
                if (run_q == QUIET_C) begin
                    end_d  = 1'b1;
                    ierr_d = (nb_q != 3'd0);
                    nb_d   = '0;
                    st_d   = IDLE;
                end else if (rise) begin
                    st_d = BAR;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            scan_s_q <= 1'b0;
            scan_p_q <= 1'b0;
            run_q    <= '0;
            ref_q    <= '0;
            sr_q     <= '0;
            nb_q     <= '0;
            i_q      <= '0;
            ivld_q   <= 1'b0;
            ierr_q   <= 1'b0;
            end_q    <= 1'b0;
            st_q     <= IDLE;
        end else begin
            sync1_q  <= scan;
            scan_s_q <= sync1_q;
            scan_p_q <= scan_s_q;
            run_q    <= run_d;
            ref_q    <= ref_d;
            sr_q     <= sr_d;
            nb_q     <= nb_d;
            i_q      <= i_d;
            ivld_q   <= ivld_d;
            ierr_q   <= ierr_d;
            end_q    <= end_d;
            st_q     <= st_d;
        end
    end

    assign I        = i_q;
    assign I_VALID  = ivld_q;
    assign I_ERR    = ierr_q;
    assign END_SCAN = end_q;
    assign state    = st_q;

endmodule

// File: tb/tb_bar_width_sampler.sv
module tb_bar_width_sampler;

    localparam int CW    = 8;
    localparam int QUIET = 64;

    logic       clock = 1'b0;
    logic       reset;
    logic       scan  = 1'b0;
    logic [4:0] I;
    logic       I_VALID, I_ERR, END_SCAN;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [4:0] i;
        logic       v;
        logic       e;
        logic       es;
    } ev_t;

    ev_t evq[$];
    int  tfall[$];

    bar_width_sampler #(.CW(CW), .QUIET(QUIET)) dut (
        .clock    (clock),
        .reset    (reset),
        .scan     (scan),
        .I        (I),
        .I_VALID  (I_VALID),
        .I_ERR    (I_ERR),
        .END_SCAN (END_SCAN),
        .state    (state)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Record every strobe with the cycle it was seen in.
    always @(negedge clock)
        if (reset === 1'b1 && (I_VALID !== 1'b0 || I_ERR !== 1'b0 || END_SCAN !== 1'b0))
            evq.push_back('{cyc, I, I_VALID, I_ERR, END_SCAN});

    // Reference: a bar is wide when it is more than 1.5x the reference width;
    // a symbol is bad unless exactly two of its five bars are wide.
    function automatic logic [5:0] sym_model(input int r, input int w[5]);
        logic [4:0] word;
        int ones;
        ones = 0;
        for (int k = 0; k < 5; k++) begin
            word[4-k] = (2 * w[k] > 3 * r);
            if (word[4-k]) ones++;
        end
        return {ones != 2, word};
    endfunction

    task automatic run(input logic lvl, input int n);
        scan = lvl;
        repeat (n) @(negedge clock);
    endtask

    task automatic bar(input int w, input int g);
        run(1'b1, w);
        tfall.push_back(cyc);
        run(1'b0, g);
    endtask

    task automatic settle();
        run(1'b0, QUIET + 10);
        evq.delete();
        tfall.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (I !== 5'd0)      begin failures++; $display("FAIL reset_I got=%b want=00000", I); end
        checks++; if (I_VALID !== 1'b0) begin failures++; $display("FAIL reset_I_VALID got=%b want=0", I_VALID); end
        checks++; if (I_ERR !== 1'b0)   begin failures++; $display("FAIL reset_I_ERR got=%b want=0", I_ERR); end
        checks++; if (END_SCAN !== 1'b0) begin failures++; $display("FAIL reset_END_SCAN got=%b want=0", END_SCAN); end
        checks++; if (state !== 2'd0)  begin failures++; $display("FAIL reset_state got=%0d want=0", state); end
        reset = 1'b1;
        run(1'b0, 5);
        checks++; if (evq.size() !== 0) begin failures++; $display("FAIL reset_no_strobe got=%0d want=0", evq.size()); end
    endtask

    task automatic test_basic();
        settle();
        bar(4, 4); bar(4, 4); bar(8, 4); bar(4, 4); bar(8, 4); bar(4, 4);
        checks++; if (evq.size() !== 1) begin failures++; $display("FAIL basic_count got=%0d want=1", evq.size()); end
        if (evq.size() == 1) begin
            checks++; if (evq[0].i !== 5'b01010 || evq[0].v !== 1'b1 || evq[0].e !== 1'b0 || evq[0].es !== 1'b0)
                begin failures++; $display("FAIL basic_word got=%b v=%b e=%b es=%b want=01010 v=1 e=0 es=0", evq[0].i, evq[0].v, evq[0].e, evq[0].es); end
            checks++; if (evq[0].cyc !== tfall[5] + 3) begin failures++; $display("FAIL basic_latency got=%0d want=%0d", evq[0].cyc, tfall[5] + 3); end
        end
        run(1'b0, QUIET + 6);
        checks++; if (evq.size() !== 2) begin failures++; $display("FAIL basic_end_count got=%0d want=2", evq.size()); end
        if (evq.size() == 2) begin
            checks++; if (evq[1].es !== 1'b1 || evq[1].e !== 1'b0 || evq[1].v !== 1'b0)
                begin failures++; $display("FAIL basic_end_strobes got es=%b e=%b v=%b want es=1 e=0 v=0", evq[1].es, evq[1].e, evq[1].v); end
            checks++; if (evq[1].cyc !== tfall[5] + QUIET + 3) begin failures++; $display("FAIL basic_end_latency got=%0d want=%0d", evq[1].cyc, tfall[5] + QUIET + 3); end
        end
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL basic_state got=%0d want=0", state); end
    endtask

    task automatic test_threshold();
        settle();
        bar(4, 3); bar(6, 3); bar(7, 3); bar(7, 3); bar(4, 3); bar(4, 5);
        checks++; if (evq.size() !== 1) begin failures++; $display("FAIL thresh_count got=%0d want=1", evq.size()); end
        if (evq.size() == 1) begin
            checks++; if (evq[0].i !== 5'b01100 || evq[0].v !== 1'b1 || evq[0].e !== 1'b0)
                begin failures++; $display("FAIL thresh_word got=%b v=%b e=%b want=01100 v=1 e=0", evq[0].i, evq[0].v, evq[0].e); end
        end
    endtask

    task automatic test_popcount();
        settle();
        bar(4, 4); bar(8, 4); bar(8, 4); bar(8, 4); bar(4, 4); bar(4, 4);
        checks++; if (evq.size() !== 1) begin failures++; $display("FAIL pop_count got=%0d want=1", evq.size()); end
        if (evq.size() == 1) begin
            checks++; if (evq[0].i !== 5'b11100 || evq[0].v !== 1'b1 || evq[0].e !== 1'b1)
                begin failures++; $display("FAIL pop_word got=%b v=%b e=%b want=11100 v=1 e=1", evq[0].i, evq[0].v, evq[0].e); end
            checks++; if (evq[0].cyc !== tfall[5] + 3) begin failures++; $display("FAIL pop_latency got=%0d want=%0d", evq[0].cyc, tfall[5] + 3); end
        end
    endtask

    task automatic test_timeout();
        settle();
        bar(4, 4); bar(4, 4); bar(8, 4);
        run(1'b0, QUIET + 10);
        checks++; if (evq.size() !== 1) begin failures++; $display("FAIL tmo_count got=%0d want=1", evq.size()); end
        if (evq.size() == 1) begin
            checks++; if (evq[0].es !== 1'b1 || evq[0].e !== 1'b1 || evq[0].v !== 1'b0)
                begin failures++; $display("FAIL tmo_strobes got es=%b e=%b v=%b want es=1 e=1 v=0", evq[0].es, evq[0].e, evq[0].v); end
            checks++; if (evq[0].cyc !== tfall[2] + QUIET + 3) begin failures++; $display("FAIL tmo_latency got=%0d want=%0d", evq[0].cyc, tfall[2] + QUIET + 3); end
        end
        checks++; if (I !== 5'b11100) begin failures++; $display("FAIL tmo_I_hold got=%b want=11100", I); end
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL tmo_state got=%0d want=0", state); end
    endtask

    task automatic test_saturation();
        int t;
        settle();
        t = cyc;
        run(1'b1, 300);
        run(1'b0, 10);
        checks++; if (evq.size() !== 1) begin failures++; $display("FAIL sat_count got=%0d want=1", evq.size()); end
        if (evq.size() == 1) begin
            checks++; if (evq[0].e !== 1'b1 || evq[0].v !== 1'b0 || evq[0].es !== 1'b0 || evq[0].i !== 5'b11100)
                begin failures++; $display("FAIL sat_strobes got e=%b v=%b es=%b I=%b want e=1 v=0 es=0 I=11100", evq[0].e, evq[0].v, evq[0].es, evq[0].i); end
            checks++; if (evq[0].cyc !== t + (1 << CW) + 2) begin failures++; $display("FAIL sat_latency got=%0d want=%0d", evq[0].cyc, t + (1 << CW) + 2); end
        end
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL sat_state got=%0d want=0", state); end
        // Light line in IDLE must not produce a timeout.
        run(1'b0, QUIET + 10);
        checks++; if (evq.size() !== 1) begin failures++; $display("FAIL idle_no_timeout got=%0d want=1", evq.size()); end
    endtask

    task automatic test_reset_mid();
        settle();
        bar(4, 4); bar(4, 4); bar(8, 4);
        run(1'b1, 2);
        reset = 1'b0;
        #1;
        checks++; if (I !== 5'd0 || I_VALID !== 1'b0 || I_ERR !== 1'b0 || END_SCAN !== 1'b0 || state !== 2'd0)
            begin failures++; $display("FAIL midrst_outputs got I=%b v=%b e=%b es=%b st=%0d want all 0", I, I_VALID, I_ERR, END_SCAN, state); end
        @(negedge clock);
        run(1'b1, 2);
        run(1'b0, 3);
        reset = 1'b1;
        run(1'b0, 5);
        checks++; if (evq.size() !== 0) begin failures++; $display("FAIL midrst_no_strobe got=%0d want=0", evq.size()); end
        tfall.delete();
        bar(5, 3); bar(5, 3); bar(9, 3); bar(9, 3); bar(5, 3); bar(5, 5);
        checks++; if (evq.size() !== 1) begin failures++; $display("FAIL midrst_count got=%0d want=1", evq.size()); end
        if (evq.size() == 1) begin
            checks++; if (evq[0].i !== 5'b01100 || evq[0].v !== 1'b1 || evq[0].e !== 1'b0 || evq[0].cyc !== tfall[5] + 3)
                begin failures++; $display("FAIL midrst_word got=%b v=%b e=%b cyc=%0d want=01100 v=1 e=0 cyc=%0d", evq[0].i, evq[0].v, evq[0].e, evq[0].cyc, tfall[5] + 3); end
        end
    endtask

    // Random scans of two back-to-back symbols, including 1-cycle bars and gaps.
    task automatic test_back_to_back();
        int         r;
        int         w[5];
        logic [5:0] exp[2];
        for (int it = 0; it < 8; it++) begin
            settle();
            r = $urandom_range(1, 30);
            bar(r, $urandom_range(1, 20));
            for (int s = 0; s < 2; s++) begin
                for (int k = 0; k < 5; k++) begin
                    w[k] = $urandom_range(1, 2 * r + 4);
                    bar(w[k], ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(1, 20));
                end
                exp[s] = sym_model(r, w);
            end
            run(1'b0, 4);
            checks++; if (evq.size() !== 2) begin failures++; $display("FAIL b2b_count it=%0d got=%0d want=2", it, evq.size()); end
            if (evq.size() == 2) begin
                for (int s = 0; s < 2; s++) begin
                    checks++; if ({evq[s].e, evq[s].i} !== exp[s] || evq[s].v !== 1'b1 || evq[s].es !== 1'b0)
                        begin failures++; $display("FAIL b2b_word it=%0d s=%0d got e=%b I=%b v=%b want e=%b I=%b v=1", it, s, evq[s].e, evq[s].i, evq[s].v, exp[s][5], exp[s][4:0]); end
                    checks++; if (evq[s].cyc !== tfall[5*s+5] + 3)
                        begin failures++; $display("FAIL b2b_latency it=%0d s=%0d got=%0d want=%0d", it, s, evq[s].cyc, tfall[5*s+5] + 3); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_threshold();
        test_popcount();
        test_timeout();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bar_width_sampler.md
# bar_width_sampler

Front-end stage of the bar-code reader: samples the raw serial optical line, measures the width of each dark bar in clock cycles, and classifies each bar as narrow (0) or wide (1) against a reference width taken from the first bar of the scan. It packs each group of five bar bits into the 5-bit word `I` that the decoder state machine consumes, with a one-cycle strobe. It also flags malformed symbols and detects the end of a scan.

## Interface
Parameters:
- `CW`, 8: width of the run-length counter; runs saturate at 2^CW-1.
- `QUIET`, 64: light-run length in cycles that ends a scan; legal range 1..2^CW-1.

Ports:
- `clock`  in  1  the single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `scan`  in  1  raw optical line, asynchronous to `clock`; 1 = dark bar, 0 = light space.
- `I`  out  5  last completed symbol; first bar of the group in bit 4, last bar in bit 0.
- `I_VALID`  out  1  one-cycle strobe; `I` is new and stable this cycle.
- `I_ERR`  out  1  one-cycle strobe; symbol or scan error (see Operation).
- `END_SCAN`  out  1  one-cycle strobe; quiet timeout reached.
- `state`  out  2  current FSM state: IDLE=0, REF=1, BAR=2, GAP=3.

## Operation
- `scan` passes through a 2-flop synchronizer to give `scan_s`. Edges are detected on `scan_s` against its previous value.
- `run` counter:
  - Clears to 1 on every edge of `scan_s`.
  - Otherwise increments each cycle.
  - Saturates at 2^CW-1.
  - A run's width is the `run` value in the last cycle before the edge that ends it.
- FSM states:
  - IDLE: waits for a rising edge, then goes to REF.
  - REF: on a falling edge, latches width into `ref_w` and goes to GAP.
  - GAP:
    - On a rising edge, goes to BAR.
    - If `run` reaches QUIET, goes to IDLE.
  - BAR: on a falling edge, classifies the bar, shifts its bit in, and goes to GAP.
- Classification: bar width `w` is wide iff 2·w > 3·ref_w. Compare at CW+2 bits with no overflow.
- Shift register and symbol completion:
  - Each classified bar shifts into a 5-bit register and increments the bar counter `nb` (0..4).
  - When the 5th bar is classified:
    - Copy the register to `I` and pulse `I_VALID`.
    - Reset `nb` to 0.
  - In the same cycle, `I_ERR` pulses if the popcount of the new word is not exactly 2 (2-of-5 check). `I_VALID` pulses regardless of `I_ERR`.
- Saturation:
  - If `run` saturates in REF or BAR: pulse `I_ERR`, clear `nb`, go to IDLE.
  - No `I_VALID` in this case. `I` keeps its old value.
- Quiet timeout: when `run` reaches QUIET in GAP:
  - Pulse `END_SCAN`.
  - If `nb`≠0, also pulse `I_ERR` in the same cycle and discard the partial symbol.
  - Go to IDLE.
- Light runs in IDLE and REF are unbounded and never time out.
- `I` holds its value until the next completed symbol.

## Timing
- Reset values:
  - `I`=0, `I_VALID`=0, `I_ERR`=0, `END_SCAN`=0, `state`=IDLE.
  - `ref_w`=0, `nb`=0, shift register=0, `run`=0, synchronizer=0.
- Reset mid-operation: everything returns to these values immediately, with no strobe. After reset, a scan already in progress is treated as a new scan: the first dark bar seen becomes the reference.
- All outputs are registered.
- `I_VALID`/`I_ERR` latency: asserted exactly 3 rising edges after the raw `scan` falling edge that ends the 5th bar (2 synchronizer edges plus 1 output register).
- `END_SCAN` latency: asserted in the cycle after `run` = QUIET is registered. That is QUIET+3 cycles after the raw falling edge of the last bar.
- Strobes last exactly one cycle and never repeat without a new event.
- `I_VALID` and `I_ERR` may coincide. `END_SCAN` and `I_VALID` never coincide, because `I_VALID` occurs only on a falling edge.
- Minimum legal run width is 1 cycle. A 1-cycle bar or gap is processed normally; there is no glitch filter.
- Back-to-back symbols: the first bar of the next symbol may start in the gap immediately following the 5th bar. No dead cycles are required.

## Test plan
- Reference bar 4, then bars 4,8,4,8,4, all gaps 4 → one `I_VALID` with `I`=5'b01010, `I_ERR`=0, 3 cycles after the 5th bar's raw falling edge.
- Threshold boundary with reference 4: bars 6,7,7,4,4 → `I`=5'b01100. Width 6 is narrow (12 > 12 is false); width 7 is wide.
- Reference 4, then bars 8,8,8,4,4 → `I_VALID`=1 with `I_ERR`=1 in the same cycle, `I`=5'b11100.
- Reference 4, then two bars, then a light line held for QUIET+10 cycles → `END_SCAN` and `I_ERR` pulse together once, no `I_VALID`, `state` returns to 0.
- Dark held for 300 cycles with CW=8 → `I_ERR` pulse at saturation, `state`=IDLE, `I` unchanged.
- Assert `reset` low during the 3rd bar of a symbol → all outputs are 0 immediately. After release, a full 6-bar scan decodes correctly.
